tmds_rx_channel: RTL and testbench
==================================

TMDS_RX_CHANNEL -- requirements
Module: tmds_rx_channel

Interface
REQ-001 Parameter LOCK_RUN, default 8: consecutive control tokens required to declare word lock.
REQ-002 Parameter SLIP_TIMEOUT, default 1024: symbols in HUNT without lock before a bit-slip request.
REQ-003 Parameter SLIP_WAIT, default 4: idle cycles after a bit-slip pulse before hunting resumes.
REQ-004 Parameter LOSS_LIMIT, default 4096: symbols in LOCKED without any control token before lock is dropped.
REQ-005 Port clk, input, 1: pixel-rate clock; the only clock.
REQ-006 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 Port sym_en, input, 1: sym_in holds a new symbol this cycle.
REQ-008 Port sym_in, input, 10: one deserialized TMDS symbol; bit 0 is the first serial bit.
REQ-009 Port dout, output, 8: decoded pixel byte.
REQ-010 Port ctrl, output, 2: decoded control bits {c1,c0}.
REQ-011 Port de, output, 1: dout is valid video data.
REQ-012 Port out_valid, output, 1: dout/ctrl/de updated this cycle.
REQ-013 Port locked, output, 1: word alignment achieved.
REQ-014 Port bitslip, output, 1: one-cycle request to the deserializer to shift word boundary by one bit.

Function
REQ-015 Control tokens SHALL be 10'h354 -> ctrl 00, 10'h0AB -> 01, 10'h154 -> 10, 10'h2AB -> 11; any other value is a data symbol.
REQ-016 Data decode SHALL be: d = sym[9] ? ~sym[7:0] : sym[7:0]; dout[0] = d[0]; for i=1..7, dout[i] = sym[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
REQ-017 Pipeline latency SHALL be 2 clk cycles: a symbol sampled with sym_en=1 at edge N appears on outputs with out_valid=1 after edge N+2.
REQ-018 Cycles with sym_en=0 SHALL produce out_valid=0 two cycles later, hold dout/ctrl/de, and leave all counters unchanged.
REQ-019 out_valid SHALL be 1 only when locked=1 for the symbol's evaluation; while unlocked out_valid=0, de=0.
REQ-020 On a token symbol: de=0, ctrl=token value, dout holds its previous value; on a data symbol: de=1, dout=decoded byte, ctrl holds.
REQ-021 FSM states SHALL be HUNT, SLIP, SLIP_HOLD, LOCKED.
REQ-022 HUNT: each enabled token increments run_cnt; each enabled data symbol clears run_cnt and increments to_cnt.
REQ-023 HUNT -> LOCKED when run_cnt reaches LOCK_RUN; run_cnt, to_cnt cleared; locked=1 from the next cycle.
REQ-024 HUNT -> SLIP when to_cnt reaches SLIP_TIMEOUT; token runs do not clear to_cnt.
REQ-025 SLIP: bitslip=1 for exactly one cycle, then SLIP_HOLD.
REQ-026 SLIP_HOLD: ignore sym_in for SLIP_WAIT cycles, clear run_cnt/to_cnt, return to HUNT.
REQ-027 LOCKED: each enabled token clears loss_cnt; each enabled data symbol increments loss_cnt; reaching LOSS_LIMIT -> HUNT, locked=0 from the next cycle, counters cleared.
REQ-028 Simultaneous run_cnt==LOCK_RUN and to_cnt==SLIP_TIMEOUT SHALL resolve to LOCKED.
REQ-029 Counters SHALL saturate, never wrap; widths are sized from the parameters.

Reset
REQ-030 While rst_n=0: state HUNT, all counters 0, dout=0, ctrl=0, de=0, out_valid=0, locked=0, bitslip=0.
REQ-031 Reset assertion SHALL take effect immediately, mid-pipeline or mid-SLIP; pipeline contents are discarded.
REQ-032 Deassertion is synchronous to clk by the integrating level; the first symbol is sampled on the first rising edge with rst_n=1.

Verification
REQ-033 Reset, then 8 symbols of 10'h354 with sym_en=1 -> locked=1 after the 8th; out_valid stays 0 for all 8.
REQ-034 Locked, feed 10'h0AB then data 10'h100 -> two cycles later ctrl=01, de=0; next cycle de=1, dout=8'h00, out_valid=1.
REQ-035 Unlocked, feed 1024 data symbols -> single bitslip pulse, then 4 idle cycles, then HUNT counts resume from 0.
REQ-036 Locked, feed 4095 data symbols, then a token, then 4096 data symbols -> lock held across the token, dropped after the 4096th.
REQ-037 Pull rst_n low during SLIP and during LOCKED -> all outputs 0 within the same cycle; no residual bitslip.
REQ-038 Random sym_en gaps with a 7-token run -> no lock; an 8th token completes the run and locked=1.

Source files
------------

// File: rtl/tmds_rx_channel.sv
// -----------------------------------------------------------------------------
// tmds_rx_channel
//   One TMDS receive lane after the deserializer. It finds the 10-bit word
//   boundary by looking for runs of control tokens, asks the deserializer to
//   bit-slip when no run turns up, and decodes aligned symbols into either a
//   pixel byte or a pair of control bits.
//
//   Word alignment FSM (HUNT / SLIP / SLIP_HOLD / LOCKED) evaluates sym_in
//   on the sampling edge. The data path is a fixed 2-cycle pipeline:
//     edge N   : capture symbol + "evaluated while locked" flag
//     edge N+1 : classify (token or data) and decode
//     edge N+2 : update dout / ctrl / de / out_valid
//
//   Handshake: out_valid is a one-cycle qualifier with no backpressure. When
//   out_valid=1, dout/ctrl/de describe one symbol that was accepted with
//   sym_en=1 while locked. When out_valid=0, dout and ctrl hold their last
//   values; de also holds across sym_en gaps but reads 0 once unlocked.
//
// Parameters (all must be >= 1)
//   LOCK_RUN      consecutive control tokens that declare word lock
//   SLIP_TIMEOUT  data symbols seen in HUNT before a bit-slip request
//   SLIP_WAIT     cycles spent ignoring input after a bit-slip pulse
//   LOSS_LIMIT    data symbols in LOCKED without any token before unlock
//
// Ports
//   clk        pixel-rate clock, the only clock
//   rst_n      asynchronous active-low reset
//   sym_en     sym_in carries a new symbol this cycle
//   sym_in     deserialized symbol, bit 0 is the first serial bit
//   dout       decoded pixel byte
//   ctrl       decoded control bits {c1,c0}
//   de         dout carries video data
//   out_valid  dout/ctrl/de updated this cycle
//   locked     word alignment achieved
//   bitslip    one-cycle request to shift the word boundary by one bit
//   fsm_state  alignment FSM state (0 HUNT, 1 SLIP, 2 SLIP_HOLD, 3 LOCKED)
// -----------------------------------------------------------------------------
module tmds_rx_channel #(
  parameter int LOCK_RUN     = 8,
  parameter int SLIP_TIMEOUT = 1024,
  parameter int SLIP_WAIT    = 4,
  parameter int LOSS_LIMIT   = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sym_en,
  input  logic [9:0] sym_in,
  output logic [7:0] dout,
  output logic [1:0] ctrl,
  output logic       de,
  output logic       out_valid,
  output logic       locked,
  output logic       bitslip,
  output logic [1:0] fsm_state
);

  // Each counter is just wide enough to hold its terminal value.
  localparam int RUN_W  = $clog2(LOCK_RUN + 1);
  localparam int TO_W   = $clog2(SLIP_TIMEOUT + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT + 1);
  localparam int LOSS_W = $clog2(LOSS_LIMIT + 1);

  localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(LOCK_RUN);
  localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(SLIP_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(SLIP_WAIT);
  localparam logic [LOSS_W-1:0] LOSS_MAX = LOSS_W'(LOSS_LIMIT);

  typedef enum logic [1:0] {
    HUNT      = 2'd0,
    SLIP      = 2'd1,
    SLIP_HOLD = 2'd2,
    LOCKED    = 2'd3
  } state_t;

  // Returns {is_token, ctrl_bits}.
  function automatic logic [2:0] classify(input logic [9:0] s);
    logic [2:0] r;
    case (s)
      10'h354: r = 3'b1_00;
      10'h0AB: r = 3'b1_01;
      10'h154: r = 3'b1_10;
      10'h2AB: r = 3'b1_11;
      default: r = 3'b0_00;
    endcase
    return r;
  endfunction

  // Undo the optional inversion (bit 9), then the XOR/XNOR transition
  // coding selected by bit 8.
  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] d;
    logic [7:0] r;
    d    = s[9] ? ~s[7:0] : s[7:0];
    r    = '0;
    r[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      r[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Alignment FSM
  // ---------------------------------------------------------------------------
  state_t              state, state_nxt;
  logic [RUN_W-1:0]    run_cnt, run_nxt, run_inc;
  logic [TO_W-1:0]     to_cnt, to_nxt, to_inc;
  logic [WAIT_W-1:0]   wait_cnt, wait_nxt, wait_inc;
  logic [LOSS_W-1:0]   loss_cnt, loss_nxt, loss_inc;
  logic [2:0]          in_cls;
  logic                in_tok;

  assign in_cls = classify(sym_in);
  assign in_tok = in_cls[2];

  // Saturating increments: counters stop at their terminal value.
  assign run_inc  = (run_cnt  == RUN_MAX)  ? run_cnt  : run_cnt  + RUN_W'(1);
  assign to_inc   = (to_cnt   == TO_MAX)   ? to_cnt   : to_cnt   + TO_W'(1);
  assign wait_inc = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + WAIT_W'(1);
  assign loss_inc = (loss_cnt == LOSS_MAX) ? loss_cnt : loss_cnt + LOSS_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HUNT;
      run_cnt  <= '0;
      to_cnt   <= '0;
      wait_cnt <= '0;
      loss_cnt <= '0;
    end else begin
      state    <= state_nxt;
      run_cnt  <= run_nxt;
      to_cnt   <= to_nxt;
      wait_cnt <= wait_nxt;
      loss_cnt <= loss_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    run_nxt   = run_cnt;
    to_nxt    = to_cnt;
    wait_nxt  = '0;
    loss_nxt  = loss_cnt;
    case (state)
      HUNT: begin
        if (sym_en) begin
          if (in_tok) begin
            run_nxt = run_inc;
          end else begin
            run_nxt = '0;
            to_nxt  = to_inc;
          end
        end
        // Lock is checked first so a run completing together with the
        // timeout wins.
        if (run_nxt == RUN_MAX) begin
          state_nxt = LOCKED;
          run_nxt   = '0;
          to_nxt    = '0;
          loss_nxt  = '0;
        end else if (to_nxt == TO_MAX) begin
          state_nxt = SLIP;
          run_nxt   = '0;
          to_nxt    = '0;
        end
      end
      SLIP: begin
        state_nxt = SLIP_HOLD;
        run_nxt   = '0;
        to_nxt    = '0;
      end
      SLIP_HOLD: begin
        // Deserializer output is unsettled right after a slip; ignore it.
        run_nxt  = '0;
        to_nxt   = '0;
        wait_nxt = wait_inc;
        if (wait_inc == WAIT_MAX) begin
          state_nxt = HUNT;
          wait_nxt  = '0;
        end
      end
      LOCKED: begin
        if (sym_en) begin
          loss_nxt = in_tok ? '0 : loss_inc;
        end
        if (loss_nxt == LOSS_MAX) begin
          state_nxt = HUNT;
          run_nxt   = '0;
          to_nxt    = '0;
          loss_nxt  = '0;
        end
      end
      default: begin
        state_nxt = HUNT;
        run_nxt   = '0;
        to_nxt    = '0;
        loss_nxt  = '0;
      end
    endcase
  end

  assign locked    = (state == LOCKED);
  assign bitslip   = (state == SLIP);
  assign fsm_state = state;

  // ---------------------------------------------------------------------------
  // Decode pipeline
  // ---------------------------------------------------------------------------
  logic       s1_vld, s1_lk;
  logic [9:0] s1_sym;
  logic       s2_vld, s2_lk, s2_tok;
  logic [1:0] s2_ctrl;
  logic [7:0] s2_data;
  logic [2:0] s1_cls;

  assign s1_cls = classify(s1_sym);

  // s*_lk remembers whether the symbol was evaluated while locked, so that
  // de can drop to 0 once lock is gone but hold across sym_en gaps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld    <= 1'b0;
      s1_lk     <= 1'b0;
      s1_sym    <= '0;
      s2_vld    <= 1'b0;
      s2_lk     <= 1'b0;
      s2_tok    <= 1'b0;
      s2_ctrl   <= '0;
      s2_data   <= '0;
      dout      <= '0;
      ctrl      <= '0;
      de        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      s1_vld    <= sym_en && (state == LOCKED);
      s1_lk     <= (state == LOCKED);
      s1_sym    <= sym_in;

      s2_vld    <= s1_vld;
      s2_lk     <= s1_lk;
      s2_tok    <= s1_cls[2];
      s2_ctrl   <= s1_cls[1:0];
      s2_data   <= decode(s1_sym);

      out_valid <= s2_vld;
      if (s2_vld) begin
        if (s2_tok) begin
          de   <= 1'b0;
          ctrl <= s2_ctrl;
        end else begin
          de   <= 1'b1;
          dout <= s2_data;
        end
      end else if (!s2_lk) begin
        de <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tmds_rx_channel.sv
// -----------------------------------------------------------------------------
// tb_tmds_rx_channel
//   Directed bench for tmds_rx_channel. Driver tasks push the expected
//   {dout, ctrl, de} word for every symbol that should come out valid; a
//   monitor on the falling edge pops and compares whenever out_valid is high
//   and checks that dout/ctrl hold when it is low. Lock, slip and reset
//   behaviour is checked directly by the main sequence.
// -----------------------------------------------------------------------------
module tb_tmds_rx_channel;

  logic       clk;
  logic       rst_n;
  logic       sym_en;
  logic [9:0] sym_in;
  logic [7:0] dout;
  logic [1:0] ctrl;
  logic       de;
  logic       out_valid;
  logic       locked;
  logic       bitslip;
  logic [1:0] fsm_state;

  int checks = 0;
  int errors = 0;
  int bs_cycles = 0;

  logic [10:0] exp_q[$];
  logic [7:0]  m_dout = 8'h00;
  logic [1:0]  m_ctrl = 2'b00;
  logic [7:0]  last_dout = 8'h00;
  logic [1:0]  last_ctrl = 2'b00;

  tmds_rx_channel dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sym_en    (sym_en),
    .sym_in    (sym_in),
    .dout      (dout),
    .ctrl      (ctrl),
    .de        (de),
    .out_valid (out_valid),
    .locked    (locked),
    .bitslip   (bitslip),
    .fsm_state (fsm_state)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic is_tok(input logic [9:0] s);
    return (s == 10'h354) || (s == 10'h0AB) || (s == 10'h154) || (s == 10'h2AB);
  endfunction

  function automatic logic [1:0] tok_ctrl(input logic [9:0] s);
    logic [1:0] c;
    c = 2'b00;
    if (s == 10'h0AB) c = 2'b01;
    if (s == 10'h154) c = 2'b10;
    if (s == 10'h2AB) c = 2'b11;
    return c;
  endfunction

  // Reference decoder for bulk random data.
  function automatic logic [7:0] ref_decode(input logic [9:0] s);
    logic [7:0] d;
    logic [7:0] x;
    d = s[7:0] ^ {8{s[9]}};
    x = d ^ {d[6:0], 1'b0};
    if (!s[8]) x = ~x;
    x[0] = d[0];
    return x;
  endfunction

  function automatic logic [9:0] rnd_data();
    logic [9:0] s;
    do s = 10'($urandom_range(0, 1023)); while (is_tok(s));
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic send(input logic [9:0] s, input logic exp_v, input logic [7:0] exp_d);
    sym_in = s;
    sym_en = 1'b1;
    if (exp_v) begin
      if (is_tok(s)) begin
        m_ctrl = tok_ctrl(s);
        exp_q.push_back({m_dout, m_ctrl, 1'b0});
      end else begin
        m_dout = exp_d;
        exp_q.push_back({m_dout, m_ctrl, 1'b1});
      end
    end
    @(posedge clk);
    #1;
    sym_en = 1'b0;
  endtask

  task automatic send_rnd_data(input int n, input logic exp_v);
    logic [9:0] s;
    for (int i = 0; i < n; i++) begin
      s = rnd_data();
      send(s, exp_v, ref_decode(s));
    end
  endtask

  task automatic idle(input int n);
    sym_en = 1'b0;
    sym_in = 10'($urandom_range(0, 1023));
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic assert_reset();
    rst_n  = 1'b0;
    sym_en = 1'b0;
    exp_q.delete();
    m_dout = 8'h00;
    m_ctrl = 2'b00;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dout"},      32'(dout), 32'h0);
    check({tag, "_ctrl"},      32'(ctrl), 32'h0);
    check({tag, "_de"},        32'(de), 32'h0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'h0);
    check({tag, "_locked"},    32'(locked), 32'h0);
    check({tag, "_bitslip"},   32'(bitslip), 32'h0);
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    logic [10:0] e;
    if (!rst_n) begin
      last_dout = 8'h00;
      last_ctrl = 2'b00;
    end else if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 32'(out_valid), 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("out_word", 32'({dout, ctrl, de}), 32'(e));
        last_dout = e[10:3];
        last_ctrl = e[2:1];
      end
    end else begin
      check("hold_dout_ctrl", 32'({dout, ctrl}), 32'({last_dout, last_ctrl}));
    end
  end

  always @(negedge clk) begin
    if (bitslip === 1'b1) bs_cycles++;
  end

  // ---------------------------------------------------------------------------
  // Directed data vectors with hand-decoded bytes
  // ---------------------------------------------------------------------------
  logic [9:0] tv_sym[9];
  logic [7:0] tv_exp[9];

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    tv_sym = '{10'h000, 10'h3F0, 10'h154, 10'h1FF, 10'h0FF, 10'h2AB, 10'h155, 10'h2AA, 10'h354};
    tv_exp = '{8'hFE,   8'h11,   8'h00,   8'h01,   8'hFF,   8'h00,   8'hFF,   8'h01,   8'h00};

    rst_n  = 1'b0;
    sym_en = 1'b0;
    sym_in = 10'h000;
    #1;
    check_all_zero("reset");
    check("reset_state", 32'(fsm_state), 32'h0);
    release_reset();

    // Eight 10'h354 tokens: lock after the 8th, nothing valid meanwhile.
    for (int i = 0; i < 8; i++) begin
      send(10'h354, 1'b0, 8'h00);
      if (i == 6) check("lock_after_7", 32'(locked), 32'h0);
    end
    check("lock_after_8", 32'(locked), 32'h1);
    check("state_locked", 32'(fsm_state), 32'h3);

    // Token then data, with explicit 2-cycle latency checks.
    send(10'h0AB, 1'b1, 8'h00);
    send(10'h100, 1'b1, 8'h00);
    check("lat_early_valid", 32'(out_valid), 32'h0);
    idle(1);
    check("lat_tok_valid", 32'(out_valid), 32'h1);
    check("lat_tok_ctrl", 32'(ctrl), 32'h1);
    check("lat_tok_de", 32'(de), 32'h0);
    idle(1);
    check("lat_dat_valid", 32'(out_valid), 32'h1);
    check("lat_dat_de", 32'(de), 32'h1);
    check("lat_dat_dout", 32'(dout), 32'h00);
    idle(1);
    check("gap_valid", 32'(out_valid), 32'h0);
    check("gap_de_hold", 32'(de), 32'h1);

    // Decode table, with sym_en gaps between some entries.
    for (int i = 0; i < 9; i++) begin
      send(tv_sym[i], 1'b1, tv_exp[i]);
      if (i % 3 == 1) idle(2);
    end
    idle(3);

    // Loss of lock: 4095 data, token, 4095 data keeps lock; 4096th drops it.
    send(10'h354, 1'b1, 8'h00);
    send_rnd_data(4095, 1'b1);
    check("loss_4095_locked", 32'(locked), 32'h1);
    send(10'h154, 1'b1, 8'h00);
    send_rnd_data(4095, 1'b1);
    check("loss_reset_by_token", 32'(locked), 32'h1);
    send_rnd_data(1, 1'b1);
    check("loss_4096_unlocked", 32'(locked), 32'h0);
    idle(3);
    check("unlocked_de", 32'(de), 32'h0);
    check("unlocked_valid", 32'(out_valid), 32'h0);

    // Slip timeout: token runs inside the count do not restart it.
    bs_cycles = 0;
    send_rnd_data(1000, 1'b0);
    for (int i = 0; i < 3; i++) send(10'h354, 1'b0, 8'h00);
    send_rnd_data(23, 1'b0);
    check("slip_1023_none", 32'(bitslip), 32'h0);
    send_rnd_data(1, 1'b0);
    check("slip_1024_pulse", 32'(bitslip), 32'h1);
    check("slip_state", 32'(fsm_state), 32'h1);
    // One symbol in SLIP plus four in SLIP_HOLD are ignored.
    for (int i = 0; i < 5; i++) begin
      send(10'h354, 1'b0, 8'h00);
      if (i == 0) check("slip_one_cycle", 32'(bitslip), 32'h0);
    end
    check("hold_ignored_state", 32'(fsm_state), 32'h0);
    for (int i = 0; i < 7; i++) send(10'h354, 1'b0, 8'h00);
    check("post_slip_run7", 32'(locked), 32'h0);
    send(10'h354, 1'b0, 8'h00);
    check("post_slip_run8", 32'(locked), 32'h1);
    check("slip_pulse_count", 32'(bs_cycles), 32'h1);

    // Reset while locked with symbols in flight.
    send(10'h100, 1'b1, 8'h00);
    send_rnd_data(2, 1'b1);
    assert_reset();
    #1;
    check_all_zero("rst_locked");
    release_reset();

    // Reset while in SLIP.
    bs_cycles = 0;
    send_rnd_data(1024, 1'b0);
    check("pre_rst_bitslip", 32'(bitslip), 32'h1);
    assert_reset();
    #1;
    check_all_zero("rst_slip");
    release_reset();
    idle(3);
    check("no_residual_bitslip", 32'(bitslip), 32'h0);
    check("rst_slip_pulses", 32'(bs_cycles), 32'h0);
    for (int i = 0; i < 8; i++) send(10'h2AB, 1'b0, 8'h00);
    check("relock_after_rst", 32'(locked), 32'h1);

    // Token run broken up by sym_en gaps.
    assert_reset();
    release_reset();
    for (int i = 0; i < 7; i++) begin
      send(10'h0AB, 1'b0, 8'h00);
      idle($urandom_range(0, 3));
    end
    check("gap_run7", 32'(locked), 32'h0);
    idle(2);
    send(10'h0AB, 1'b0, 8'h00);
    check("gap_run8", 32'(locked), 32'h1);
    for (int i = 0; i < 6; i++) begin
      send_rnd_data(1, 1'b1);
      idle($urandom_range(0, 3));
    end
    send(10'h154, 1'b1, 8'h00);
    idle(4);

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
